// File: rtl/aes_pkg.sv
// Shared AES encodings, round counts and controller state type.
// Used by the decrypt controller and by the encrypt controller.
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;
  localparam logic [1:0] MODE_ILL = 2'd3;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Round number at which the datapath performs its final transform.
  localparam int ROUND_LAST = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ABORT = 2'd3
  } dec_state_t;

  function automatic logic mode_legal(input logic [1:0] m);
    return m != MODE_ILL;
  endfunction

endpackage

// File: rtl/aes_nr_lut.sv
// Key size to round count (Nr) and starting round number (Nr + ROUND_LAST).
// Purely combinational; shared by the encrypt and decrypt controllers.
module aes_nr_lut
  import aes_pkg::*;
#(
  parameter int RW = 5,
  parameter int KW = 4
) (
  input  logic [1:0]    mode,
  output logic [KW-1:0] nr,
  output logic [RW-1:0] round_init
);

  always_comb begin
    nr = KW'(NR_128);
    case (mode)
      MODE_192: nr = KW'(NR_192);
      MODE_256: nr = KW'(NR_256);
      default:  nr = KW'(NR_128);
    endcase
    round_init = RW'(nr) + RW'(ROUND_LAST);
  end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Inverse-round sequencer for the AES decrypt datapath and key store.
// Defining AES_DEC_BLKCNT_EN adds the blk_cnt completed-block counter output.
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int RW = 5,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode_in,
  input  logic          keygen,
  input  logic          enc,
  output logic          set,
  output logic [RW-1:0] round,
  output logic [1:0]    mode,
  output logic [KW-1:0] key_idx,
  output logic          done,
  output logic          busy,
  output logic          err
`ifdef AES_DEC_BLKCNT_EN
  ,
  output logic [15:0]   blk_cnt
`endif
);

  dec_state_t    state;
  logic [RW-1:0] round_q;
  logic [KW-1:0] nr;
  logic [RW-1:0] round_init;
  logic [RW-1:0] round_last;
  logic          hold;
  logic          last;

  assign round_last = RW'(ROUND_LAST);
  assign hold       = keygen | enc;
  assign last       = (state == RUN) && (round_q == round_last);

  aes_nr_lut #(
    .RW(RW),
    .KW(KW)
  ) u_nr_lut (
    .mode       (mode),
    .nr         (nr),
    .round_init (round_init)
  );

  // During LOAD the round/key values come straight from the lookup on the
  // freshly captured mode; from RUN onwards the counter register drives them.
  always_comb begin
    round   = round_q;
    key_idx = '0;
    if (state == LOAD) begin
      round   = round_init;
      key_idx = nr;
    end else if (round_q >= round_last) begin
      key_idx = KW'(round_q - round_last);
    end
  end

  // A shared-resource claim in the final round suppresses the done pulse.
  assign done = last && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      set     <= 1'b0;
      busy    <= 1'b0;
      mode    <= MODE_128;
      err     <= 1'b0;
      round_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!mode_legal(mode_in)) begin
              err <= 1'b1;
            end else if (!hold) begin
              mode  <= mode_in;
              err   <= 1'b0;
              set   <= 1'b1;
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          set <= 1'b0;
          if (hold) begin
            busy    <= 1'b0;
            round_q <= '0;
            state   <= ABORT;
          end else begin
            round_q <= round_init;
            state   <= RUN;
          end
        end
        RUN: begin
          if (hold) begin
            busy    <= 1'b0;
            round_q <= '0;
            state   <= ABORT;
          end else if (last) begin
            busy    <= 1'b0;
            round_q <= '0;
            state   <= IDLE;
          end else begin
            round_q <= round_q - 1'b1;
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          set     <= 1'b0;
          busy    <= 1'b0;
          round_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_DEC_BLKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (done) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Scoreboard bench for aes_dec_round_ctrl: randomized decrypt requests,
// aborts and illegal modes checked against a cycle-timeline reference model.
module tb_aes_dec_round_ctrl;

  localparam int RW = 5;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic          keygen = 1'b0;
  logic          enc = 1'b0;
  logic          set;
  logic [RW-1:0] round;
  logic [1:0]    mode;
  logic [KW-1:0] key_idx;
  logic          done;
  logic          busy;
  logic          err;
`ifdef AES_DEC_BLKCNT_EN
  logic [15:0]   blk_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_cyc = 0;
  int n_done = 0;
  bit monitor_on = 1'b0;
  logic err_now = 1'b0;

  typedef struct {
    int         cyc;
    logic       set;
    int         round;
    int         key;
    logic       done;
    logic [1:0] mode;
  } exp_t;

  typedef struct {
    int   cyc;
    logic err;
  } err_t;

  exp_t exp_q[$];
  err_t err_q[$];

  aes_dec_round_ctrl #(
    .RW(RW),
    .KW(KW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode_in (mode_in),
    .keygen  (keygen),
    .enc     (enc),
    .set     (set),
    .round   (round),
    .mode    (mode),
    .key_idx (key_idx),
    .done    (done),
    .busy    (busy),
    .err     (err)
`ifdef AES_DEC_BLKCNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int nr_of(input int m);
    return 10 + 2 * m;
  endfunction

  // Expected timeline of one block accepted in cycle c; h >= 0 is the cycle
  // in which keygen/enc is raised, which cuts the block short.
  task automatic push_block(input int c, input int m, input int h);
    int   n;
    exp_t e;
    n = nr_of(m);
    e.cyc = c + 1; e.set = 1'b1; e.round = n + 2; e.key = n; e.done = 1'b0; e.mode = m[1:0];
    exp_q.push_back(e);
    for (int i = 0; i <= n; i++) begin
      if (h >= 0 && c + 2 + i > h) break;
      e.cyc   = c + 2 + i;
      e.set   = 1'b0;
      e.round = n + 2 - i;
      e.key   = n - i;
      e.done  = (i == n) && (c + 2 + i != h);
      e.mode  = m[1:0];
      exp_q.push_back(e);
    end
    if (h < 0) begin
      free_cyc = c + n + 3;
      n_done++;
    end else begin
      free_cyc = h + 2;
    end
    err_q.push_back('{cyc: c + 1, err: 1'b0});
  endtask

  task automatic wait_idle();
    while (cyc < free_cyc) @(negedge clk);
  endtask

  task automatic rand_block(input bit allow_abort);
    int m, n, c, h;
    bit spur, kg;
    m = int'($urandom_range(0, 2));
    n = nr_of(m);
    h = -1;
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    c = cyc;
    if (allow_abort && $urandom_range(0, 2) == 0) h = c + 1 + int'($urandom_range(0, n + 1));
    spur = ($urandom_range(0, 1) == 1) && (h < 0 || h >= c + 2);
    kg = $urandom_range(0, 1) == 1;
    push_block(c, m, h);
    start = 1'b1;
    mode_in = m[1:0];
    @(negedge clk);
    while (cyc < free_cyc) begin
      start   = spur && (cyc == c + 3);
      mode_in = start ? 2'd3 : 2'($urandom_range(0, 2));
      keygen  = (cyc == h) && kg;
      enc     = (cyc == h) && !kg;
      @(negedge clk);
    end
    start = 1'b0; keygen = 1'b0; enc = 1'b0;
  endtask

  // Monitor: samples 2 time units after each falling edge.
  initial begin : monitor
    exp_t e;
    err_t ee;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
        err_q.delete();
        err_now = 1'b0;
        continue;
      end
      if (!monitor_on) continue;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_output cycle %0d: nothing presented, expected round=%0d", e.cyc, e.round);
      end
      if (set || busy || done) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("set", set, e.set);
          chk("round", round, e.round);
          chk("key_idx", key_idx, e.key);
          chk("done", done, e.done);
          chk("mode", mode, e.mode);
          chk("busy", busy, 1);
        end else begin
          checks++; errors++;
          $display("FAIL unexpected_output at cycle %0d: set=%0d busy=%0d done=%0d, expected idle",
                   cyc, set, busy, done);
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_output at cycle %0d: idle, expected round=%0d busy=1", cyc, e.round);
        end
        chk("idle_round", round, 0);
        chk("idle_key_idx", key_idx, 0);
      end
      if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
        ee = err_q.pop_front();
        err_now = ee.err;
      end
      chk("err", err, err_now);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int c, m, n;
    repeat (2) @(negedge clk);
    chk("rst_set", set, 0);
    chk("rst_round", round, 0);
    chk("rst_mode", mode, 0);
    chk("rst_key_idx", key_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    free_cyc = cyc;
    monitor_on = 1'b1;

    // Directed: one block each of AES-128, AES-192, AES-256.
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      c = cyc;
      push_block(c, k, -1);
      start = 1'b1; mode_in = 2'(k);
      @(negedge clk);
      start = 1'b0;
    end

    // Illegal mode sets err and does not start; a legal start clears it.
    wait_idle();
    err_q.push_back('{cyc: cyc + 1, err: 1'b1});
    start = 1'b1; mode_in = 2'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("err_busy_stays_0", busy, 0);

    // Request while encryption owns the key store is dropped, not queued.
    start = 1'b1; mode_in = 2'd0; enc = 1'b1;
    @(negedge clk);
    start = 1'b0; enc = 1'b0;
    repeat (2) @(negedge clk);
    free_cyc = cyc;

    // Legal start after the error; abort from keygen when round reaches 7.
    c = cyc;
    push_block(c, 0, c + 7);
    start = 1'b1; mode_in = 2'd0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 7) @(negedge clk);
    keygen = 1'b1;
    @(negedge clk);
    keygen = 1'b0;
    wait_idle();

    // Start held high across two blocks: back-to-back with one idle cycle.
    m = 1; n = nr_of(m);
    c = cyc;
    push_block(c, m, -1);
    push_block(c + n + 3, m, -1);
    start = 1'b1; mode_in = 2'(m);
    while (cyc <= c + n + 3) @(negedge clk);
    start = 1'b0;
    wait_idle();

    for (int k = 0; k < 40; k++) rand_block(1'b1);
    wait_idle();
`ifdef AES_DEC_BLKCNT_EN
    chk("blk_cnt", blk_cnt, n_done);
`endif

    // Asynchronous reset in the middle of a block, at round 5.
    wait_idle();
    c = cyc;
    push_block(c, 0, -1);
    start = 1'b1; mode_in = 2'd0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 9) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_set", set, 0);
    chk("arst_round", round, 0);
    chk("arst_mode", mode, 0);
    chk("arst_key_idx", key_idx, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    n_done = 0;
`ifdef AES_DEC_BLKCNT_EN
    chk("arst_blk_cnt", blk_cnt, 0);
`endif
    @(negedge clk);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    free_cyc = cyc;

    for (int k = 0; k < 6; k++) rand_block(1'b0);
    wait_idle();
`ifdef AES_DEC_BLKCNT_EN
    chk("blk_cnt_after_reset", blk_cnt, n_done);
`endif
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d expected outputs never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
